scratch_pad_pp: RTL and testbench
=================================

Name: scratch_pad_pp

Overview:
Double-buffered (ping-pong) scratchpad feeding the systolic-array grid from a single clock domain. The host fills the inactive ("fill") buffer of the activation and weight banks through a 32-bit port. A sequencer streams rows from the active buffer to the arrays under a valid/ready handshake. A swap handshake exchanges the buffers, so the next layer loads while the current one computes.

Parameters:
WIDTH, 16, element width in bits
HOST_W, 32, host data width; one bank row is 2*HOST_W bits, written as two halves
ACT_BANKS, 1, activation banks (one per systolic row group)
WGT_BANKS, 4, weight banks (one per systolic column group)
DEPTH, 8, rows per buffer per bank (power of two, >=2)
AW, 3, row address width = log2(DEPTH)
NW, 6, bank-select width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  host access enable
wen  in  1  host write enable (qualified by en)
bram_type  in  1  0 = activation bank, 1 = weight bank
bram_num  in  NW  bank index within type
bram_addr  in  AW  row address in fill buffer
bram_half  in  1  0 = bits [HOST_W-1:0], 1 = upper half of row
data_in  in  HOST_W  host write data
HRDATA  out  HOST_W  host read data, registered
swap  in  1  buffer-swap request (pulse)
swap_done  out  1  one-cycle pulse when swap applied
active_buf  out  1  index of buffer currently streamed
start  in  1  begin streaming (pulse)
num_rows  in  AW+1  rows to stream, 1..DEPTH
busy  out  1  streaming in progress
out_valid  out  1  data_out_* hold a valid row
out_ready  in  1  consumer accepts row
out_last  out  1  current row is final row of stream
data_out_a  out  ACT_BANKS*2*HOST_W  concatenated activation rows, bank 0 at LSBs
data_out_b  out  WGT_BANKS*2*HOST_W  concatenated weight rows, bank 0 at LSBs

Behaviour:
- Reset: active_buf=0, busy=0, out_valid=0, out_last=0, swap_done=0, HRDATA=0, data_out_*=0, pending swap cleared. Memory contents are not reset.
- Storage: per bank, 2 buffers x DEPTH rows x 2*HOST_W bits. The fill buffer is always the one not equal to active_buf.
- Host write: when en&wen and bram_num is in range for the type, write data_in to the selected half of fill[bram_addr] at the clock edge. An out-of-range bram_num is ignored.
- Host read: when en&~wen, HRDATA <= selected half of fill[bram_addr] on the next edge (1-cycle latency). An out-of-range bank returns 0. HRDATA holds its value when en=0.
- FSM IDLE:
  - start with num_rows!=0 -> RUN. rows_total = min(num_rows, DEPTH). row_ptr=0. busy=1 on the next cycle.
  - start with num_rows=0 is ignored.
- FSM RUN:
  - The output register loads row row_ptr of the active buffer (all banks in parallel) whenever ~out_valid | out_ready.
  - out_valid=1 and out_last=(row_ptr==rows_total-1) with the loaded row.
  - First beat: out_valid rises the cycle after start is accepted.
  - A beat transfers when out_valid&out_ready. With out_ready held high the stream is one row per cycle.
  - With out_ready=0, data_out_*, out_valid and out_last hold stable.
  - After the beat with out_last transfers: out_valid=0 next cycle, busy=0, return to IDLE (or SWAP if pending).
- start while busy is ignored.
- Swap:
  - In IDLE, swap toggles active_buf on the next edge and pulses swap_done for one cycle.
  - swap during RUN sets pending. It is applied the cycle after the last beat transfers; swap_done pulses then.
  - A second swap while pending is absorbed; there is no double toggle.
- swap and start in the same IDLE cycle: swap applies first, and the stream reads the newly active buffer.
- Host write in the same cycle a swap applies: the write lands in the pre-swap fill buffer, i.e. the buffer becoming active.
- Host writes during RUN go only to the fill buffer and never alter the streaming data.
- rst asserted mid-stream: aborts the stream immediately. Outputs take reset values on the next edge, and the pending swap is dropped.

Test Plan:
- Write act bank0 row2 halves 0xAAAA0001/0xBBBB0002 and weight bank3 row2 0x11111111/0x22222222. Swap. Start num_rows=3, out_ready=1 -> out_valid cycles 1-3. Row 2 data_out_a=0xBBBB0002AAAA0001 and data_out_b[255:192]=0x2222222211111111, with out_last only on beat 3.
- Host read after write: write 0xDEADBEEF to weight bank1 row5 half0, read next cycle -> HRDATA=0xDEADBEEF one cycle after read. A read of bram_num=9 (weights) returns 0, and a write there is dropped.
- Backpressure: stream 4 rows with out_ready low for 3 cycles on beat 2 -> data/out_valid stable, no row skipped or duplicated, total 4 beats.
- Swap during RUN: swap on beat 1 of 4 -> active_buf unchanged until the cycle after the last beat. swap_done pulses once, and a repeated swap request gives a single toggle.
- Boundaries: start with num_rows=0 -> no beats, busy stays 0. num_rows=15 with DEPTH=8 -> exactly 8 beats. start while busy -> ignored.
- rst asserted on beat 2 -> next cycle out_valid=0, busy=0, active_buf=0. A fresh start then streams from row 0.

Source files
------------

// File: rtl/scratch_pad_pp_if.sv
// Host access, swap/start control and row-stream signals of the ping-pong scratchpad.
// master = host/consumer side, slave = scratchpad side.
interface scratch_pad_pp_if #(
    parameter int unsigned HOST_W    = 32,
    parameter int unsigned ACT_BANKS = 1,
    parameter int unsigned WGT_BANKS = 4,
    parameter int unsigned AW        = 3,
    parameter int unsigned NW        = 6
) ();
    logic                            en;
    logic                            wen;
    logic                            bram_type;
    logic [NW-1:0]                   bram_num;
    logic [AW-1:0]                   bram_addr;
    logic                            bram_half;
    logic [HOST_W-1:0]               data_in;
    logic [HOST_W-1:0]               HRDATA;
    logic                            swap;
    logic                            swap_done;
    logic                            active_buf;
    logic                            start;
    logic [AW:0]                     num_rows;
    logic                            busy;
    logic                            out_valid;
    logic                            out_ready;
    logic                            out_last;
    logic [ACT_BANKS*2*HOST_W-1:0]   data_out_a;
    logic [WGT_BANKS*2*HOST_W-1:0]   data_out_b;

    modport master (
        output en, wen, bram_type, bram_num, bram_addr, bram_half, data_in,
        output swap, start, num_rows, out_ready,
        input  HRDATA, swap_done, active_buf, busy, out_valid, out_last,
        input  data_out_a, data_out_b
    );

    modport slave (
        input  en, wen, bram_type, bram_num, bram_addr, bram_half, data_in,
        input  swap, start, num_rows, out_ready,
        output HRDATA, swap_done, active_buf, busy, out_valid, out_last,
        output data_out_a, data_out_b
    );
endinterface

// File: rtl/scratch_pad_pp.sv
// Double-buffered activation/weight scratchpad: host fills one buffer while the other
// is streamed row by row to the systolic array under a valid/ready handshake.
module scratch_pad_pp #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned HOST_W    = 32,
    parameter int unsigned ACT_BANKS = 1,
    parameter int unsigned WGT_BANKS = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AW        = 3,
    parameter int unsigned NW        = 6
) (
    input logic              clk,
    input logic              rst,
    scratch_pad_pp_if.slave  bus
);
    localparam int unsigned RowW      = 2 * HOST_W;
    localparam int unsigned RowElems  = RowW / WIDTH;
    localparam int unsigned HalfElems = RowElems / 2;

    typedef logic [RowElems-1:0][WIDTH-1:0] row_t;
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    row_t act_mem [ACT_BANKS][2][DEPTH];
    row_t wgt_mem [WGT_BANKS][2][DEPTH];

    state_e                         state_q, state_d;
    logic                           active_buf_q, pending_q, swap_done_q;
    logic                           out_valid_q, out_last_q;
    logic [AW-1:0]                  row_ptr_q;
    logic [AW:0]                    rows_total_q;
    logic [HOST_W-1:0]              hrdata_q;
    logic [ACT_BANKS*RowW-1:0]      data_a_q, stream_a;
    logic [WGT_BANKS*RowW-1:0]      data_b_q, stream_b;

    logic accept, load, last_xfer, swap_apply, set_pending;
    logic fill_buf, rd_buf, host_wr, host_rd;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       rows_total_d, tot;
    row_t              rd_row;
    logic [HOST_W-1:0] rd_half;

    assign fill_buf = ~active_buf_q;
    assign host_wr  = bus.en & bus.wen;
    assign host_rd  = bus.en & ~bus.wen;

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (last_xfer) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        accept      = 1'b0;
        load        = 1'b0;
        last_xfer   = 1'b0;
        swap_apply  = 1'b0;
        set_pending = 1'b0;
        case (state_q)
            StIdle: begin
                accept     = bus.start && (bus.num_rows != '0);
                swap_apply = bus.swap;
            end
            StRun: begin
                last_xfer   = out_valid_q && bus.out_ready && out_last_q;
                load        = (!out_valid_q || bus.out_ready) && !last_xfer;
                // A swap arriving on the final handshake is applied right away.
                swap_apply  = last_xfer && (pending_q || bus.swap);
                set_pending = bus.swap && !last_xfer;
            end
            default: ;
        endcase
    end

    // Same-cycle swap+start streams the buffer that is becoming active.
    assign rd_buf       = swap_apply ? ~active_buf_q : active_buf_q;
    assign rd_ptr       = accept ? '0 : row_ptr_q;
    assign rows_total_d = (bus.num_rows > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_rows;
    assign tot          = accept ? rows_total_d : rows_total_q;

    always_comb begin
        stream_a = '0;
        stream_b = '0;
        for (int b = 0; b < ACT_BANKS; b++) stream_a[b*RowW +: RowW] = act_mem[b][rd_buf][rd_ptr];
        for (int b = 0; b < WGT_BANKS; b++) stream_b[b*RowW +: RowW] = wgt_mem[b][rd_buf][rd_ptr];
    end

    always_comb begin
        rd_row = '0;
        for (int b = 0; b < ACT_BANKS; b++)
            if (!bus.bram_type && NW'(b) == bus.bram_num) rd_row = act_mem[b][fill_buf][bus.bram_addr];
        for (int b = 0; b < WGT_BANKS; b++)
            if (bus.bram_type && NW'(b) == bus.bram_num) rd_row = wgt_mem[b][fill_buf][bus.bram_addr];
        rd_half = bus.bram_half ? rd_row[RowElems-1 -: HalfElems] : rd_row[HalfElems-1:0];
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < ACT_BANKS; b++) begin
            if (host_wr && !bus.bram_type && NW'(b) == bus.bram_num) begin
                if (bus.bram_half)
                    act_mem[b][fill_buf][bus.bram_addr][RowElems-1 -: HalfElems] <= bus.data_in;
                else
                    act_mem[b][fill_buf][bus.bram_addr][HalfElems-1:0] <= bus.data_in;
            end
        end
        for (int b = 0; b < WGT_BANKS; b++) begin
            if (host_wr && bus.bram_type && NW'(b) == bus.bram_num) begin
                if (bus.bram_half)
                    wgt_mem[b][fill_buf][bus.bram_addr][RowElems-1 -: HalfElems] <= bus.data_in;
                else
                    wgt_mem[b][fill_buf][bus.bram_addr][HalfElems-1:0] <= bus.data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_buf_q <= 1'b0;
            pending_q    <= 1'b0;
            swap_done_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            row_ptr_q    <= '0;
            rows_total_q <= '0;
            hrdata_q     <= '0;
            data_a_q     <= '0;
            data_b_q     <= '0;
        end else begin
            swap_done_q <= swap_apply;
            if (swap_apply) active_buf_q <= ~active_buf_q;
            if (set_pending)    pending_q <= 1'b1;
            else if (last_xfer) pending_q <= 1'b0;
            if (host_rd) hrdata_q <= rd_half;
            if (accept) rows_total_q <= rows_total_d;
            if (accept || load) begin
                out_valid_q <= 1'b1;
                out_last_q  <= ((AW+1)'(rd_ptr) == tot - (AW+1)'(1));
                data_a_q    <= stream_a;
                data_b_q    <= stream_b;
                row_ptr_q   <= rd_ptr + AW'(1);
            end else if (last_xfer) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.HRDATA     = hrdata_q;
    assign bus.swap_done  = swap_done_q;
    assign bus.active_buf = active_buf_q;
    assign bus.busy       = (state_q == StRun);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.data_out_a = data_a_q;
    assign bus.data_out_b = data_b_q;
endmodule

// File: tb/tb_scratch_pad_pp.sv
// Scoreboard bench for scratch_pad_pp: stimulus pushes expected rows, a negedge monitor
// pops and compares each transferred beat.
module tb_scratch_pad_pp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scratch_pad_pp_if #(.HOST_W(32), .ACT_BANKS(1), .WGT_BANKS(4), .AW(3), .NW(6)) bus ();

    scratch_pad_pp #(
        .WIDTH(16), .HOST_W(32), .ACT_BANKS(1), .WGT_BANKS(4), .DEPTH(8), .AW(3), .NW(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [63:0]  a;
        logic [255:0] b;
        logic         last;
    } beat_t;

    int          checks   = 0;
    int          failures = 0;
    int          beats    = 0;
    beat_t       sb[$];
    logic [63:0] act_m [2][8];
    logic [63:0] wgt_m [4][2][8];
    logic        m_active;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(int t, int bk, int bf, int r, int h);
        return {4'(t), 4'(bk), 4'(bf), 4'(r), 4'(h), 12'h5A5};
    endfunction

    task automatic model_write(input logic t, input int num, input int addr, input logic half,
                               input logic [31:0] d);
        logic fb;
        fb = ~m_active;
        if (!t && num < 1) begin
            if (half) act_m[fb][addr][63:32] = d;
            else      act_m[fb][addr][31:0]  = d;
        end else if (t && num < 4) begin
            if (half) wgt_m[num][fb][addr][63:32] = d;
            else      wgt_m[num][fb][addr][31:0]  = d;
        end
    endtask

    task automatic host_write(input logic t, input int num, input int addr, input logic half,
                              input logic [31:0] d);
        bus.en = 1'b1; bus.wen = 1'b1; bus.bram_type = t; bus.bram_num = 6'(num);
        bus.bram_addr = 3'(addr); bus.bram_half = half; bus.data_in = d;
        model_write(t, num, addr, half, d);
        tick();
        bus.en = 1'b0; bus.wen = 1'b0;
    endtask

    task automatic host_read(input logic t, input int num, input int addr, input logic half,
                             output logic [31:0] q);
        bus.en = 1'b1; bus.wen = 1'b0; bus.bram_type = t; bus.bram_num = 6'(num);
        bus.bram_addr = 3'(addr); bus.bram_half = half;
        tick();
        q = bus.HRDATA;
        bus.en = 1'b0;
    endtask

    task automatic do_swap();
        bus.swap = 1'b1;
        tick();
        bus.swap = 1'b0;
        m_active = ~m_active;
        chk("swap_done_pulse", 256'(bus.swap_done), 256'(1));
        chk("active_buf_swap", 256'(bus.active_buf), 256'(m_active));
        tick();
        chk("swap_done_clear", 256'(bus.swap_done), 256'(0));
    endtask

    task automatic push_row(input int r, input logic last);
        beat_t e;
        e.a    = act_m[m_active][r];
        e.b    = {wgt_m[3][m_active][r], wgt_m[2][m_active][r],
                  wgt_m[1][m_active][r], wgt_m[0][m_active][r]};
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic push_stream(input int n);
        int nn;
        nn = (n > 8) ? 8 : n;
        for (int r = 0; r < nn; r++) push_row(r, r == nn - 1);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (!bus.busy && !bus.out_valid) done = 1'b1;
            else tick();
        end
        chk("idle_timeout", 256'(done), 256'(1));
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            beats++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got data_out_a %0h expected no beat",
                         bus.data_out_a);
            end else begin
                e = sb.pop_front();
                chk("beat_a", 256'(bus.data_out_a), 256'(e.a));
                chk("beat_b", bus.data_out_b, e.b);
                chk("beat_last", 256'(bus.out_last), 256'(e.last));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        int          b0;
        rst = 1'b1; m_active = 1'b0;
        bus.en = 0; bus.wen = 0; bus.bram_type = 0; bus.bram_num = '0; bus.bram_addr = '0;
        bus.bram_half = 0; bus.data_in = '0; bus.swap = 0; bus.start = 0; bus.num_rows = '0;
        bus.out_ready = 0;
        tick(); tick();
        chk("rst_active_buf", 256'(bus.active_buf), 256'(0));
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("rst_out_last", 256'(bus.out_last), 256'(0));
        chk("rst_swap_done", 256'(bus.swap_done), 256'(0));
        chk("rst_hrdata", 256'(bus.HRDATA), 256'(0));
        chk("rst_data_a", 256'(bus.data_out_a), 256'(0));
        chk("rst_data_b", bus.data_out_b, 256'(0));
        rst = 1'b0;

        // Preload every row of both buffers so streamed data is always defined.
        for (int bf = 1; bf >= 0; bf--) begin
            for (int r = 0; r < 8; r++)
                for (int h = 0; h < 2; h++) begin
                    host_write(0, 0, r, h[0], pat(0, 0, bf, r, h));
                    for (int k = 0; k < 4; k++) host_write(1, k, r, h[0], pat(1, k, bf, r, h));
                end
            do_swap();
        end

        // Directed row contents, then stream three rows.
        host_write(0, 0, 2, 0, 32'hAAAA0001);
        host_write(0, 0, 2, 1, 32'hBBBB0002);
        host_write(1, 3, 2, 0, 32'h11111111);
        host_write(1, 3, 2, 1, 32'h22222222);
        do_swap();
        bus.out_ready = 1'b1; bus.num_rows = 4'd3;
        push_stream(3);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("t1_valid_c1", 256'(bus.out_valid), 256'(1));
        chk("t1_busy_c1", 256'(bus.busy), 256'(1));
        chk("t1_last_c1", 256'(bus.out_last), 256'(0));
        tick();
        chk("t1_last_c2", 256'(bus.out_last), 256'(0));
        tick();
        chk("t1_valid_c3", 256'(bus.out_valid), 256'(1));
        chk("t1_last_c3", 256'(bus.out_last), 256'(1));
        chk("t1_row2_a", 256'(bus.data_out_a), 256'(64'hBBBB0002AAAA0001));
        chk("t1_row2_b3", 256'(bus.data_out_b[255:192]), 256'(64'h2222222211111111));
        tick();
        chk("t1_valid_end", 256'(bus.out_valid), 256'(0));
        chk("t1_busy_end", 256'(bus.busy), 256'(0));

        // Host read-back and out-of-range bank handling.
        host_write(1, 1, 5, 0, 32'hDEADBEEF);
        host_read(1, 1, 5, 0, q);
        chk("rd_deadbeef", 256'(q), 256'(32'hDEADBEEF));
        tick();
        chk("rd_hold", 256'(bus.HRDATA), 256'(32'hDEADBEEF));
        host_read(1, 9, 5, 0, q);
        chk("rd_oob_wgt", 256'(q), 256'(0));
        host_write(1, 9, 5, 0, 32'h12345678);
        host_read(1, 1, 5, 0, q);
        chk("wr_oob_dropped", 256'(q), 256'(32'hDEADBEEF));
        host_read(0, 1, 0, 0, q);
        chk("rd_oob_act", 256'(q), 256'(0));
        host_read(0, 0, 2, 1, q);
        chk("rd_act_fill", 256'(q), 256'(pat(0, 0, 0, 2, 1)));

        // Backpressure on beat 2 for three cycles.
        b0 = beats;
        push_stream(4);
        bus.num_rows = 4'd4; bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", 256'(bus.out_valid), 256'(1));
            chk("bp_data_a", 256'(bus.data_out_a), 256'(act_m[m_active][1]));
            chk("bp_last", 256'(bus.out_last), 256'(0));
            tick();
        end
        bus.out_ready = 1'b1;
        wait_idle();
        chk("bp_beats", 256'(beats - b0), 256'(4));
        chk("bp_sb_empty", 256'(sb.size()), 256'(0));

        // Swap requested twice during a 4-row stream: one deferred toggle.
        push_stream(4);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.swap = 1'b1; tick();
        chk("sr_active_c2", 256'(bus.active_buf), 256'(1));
        chk("sr_done_c2", 256'(bus.swap_done), 256'(0));
        tick();
        chk("sr_active_c3", 256'(bus.active_buf), 256'(1));
        chk("sr_done_c3", 256'(bus.swap_done), 256'(0));
        bus.swap = 1'b0; tick();
        chk("sr_active_c4", 256'(bus.active_buf), 256'(1));
        chk("sr_last_c4", 256'(bus.out_last), 256'(1));
        tick();
        m_active = 1'b0;
        chk("sr_valid_c5", 256'(bus.out_valid), 256'(0));
        chk("sr_active_c5", 256'(bus.active_buf), 256'(0));
        chk("sr_done_c5", 256'(bus.swap_done), 256'(1));
        tick();
        chk("sr_active_c6", 256'(bus.active_buf), 256'(0));
        chk("sr_done_c6", 256'(bus.swap_done), 256'(0));

        // num_rows=0 ignored; num_rows=15 clamps to 8; start while busy ignored.
        bus.num_rows = 4'd0; bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("nr0_busy", 256'(bus.busy), 256'(0));
        chk("nr0_valid", 256'(bus.out_valid), 256'(0));
        tick();
        chk("nr0_busy2", 256'(bus.busy), 256'(0));
        b0 = beats;
        push_stream(15);
        bus.num_rows = 4'd15; bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.num_rows = 4'd2; tick();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        wait_idle();
        chk("clamp_beats", 256'(beats - b0), 256'(8));
        chk("clamp_sb_empty", 256'(sb.size()), 256'(0));

        // Swap, start and host write in one idle cycle.
        bus.swap = 1'b1; bus.start = 1'b1; bus.num_rows = 4'd3;
        bus.en = 1'b1; bus.wen = 1'b1; bus.bram_type = 1'b0; bus.bram_num = '0;
        bus.bram_addr = 3'd2; bus.bram_half = 1'b0; bus.data_in = 32'hCAFEF00D;
        model_write(0, 0, 2, 0, 32'hCAFEF00D);
        m_active = 1'b1;
        push_stream(3);
        tick();
        bus.swap = 1'b0; bus.start = 1'b0; bus.en = 1'b0; bus.wen = 1'b0;
        chk("ss_active", 256'(bus.active_buf), 256'(1));
        chk("ss_done", 256'(bus.swap_done), 256'(1));
        tick(); tick();
        chk("ss_row2_a", 256'(bus.data_out_a), 256'(64'hBBBB0002CAFEF00D));
        wait_idle();

        // Reset mid-stream with a swap pending.
        push_row(0, 1'b0);
        bus.num_rows = 4'd4; bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.swap = 1'b1; tick(); bus.swap = 1'b0;
        rst = 1'b1; tick();
        chk("rs_valid", 256'(bus.out_valid), 256'(0));
        chk("rs_busy", 256'(bus.busy), 256'(0));
        chk("rs_active", 256'(bus.active_buf), 256'(0));
        chk("rs_last", 256'(bus.out_last), 256'(0));
        chk("rs_data_a", 256'(bus.data_out_a), 256'(0));
        rst = 1'b0; tick();
        m_active = 1'b0;
        chk("rs_active_after", 256'(bus.active_buf), 256'(0));
        chk("rs_no_swap_done", 256'(bus.swap_done), 256'(0));
        push_stream(2);
        bus.num_rows = 4'd2; bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("rs_restart_row0", 256'(bus.data_out_a), 256'(act_m[0][0]));
        wait_idle();
        chk("final_sb_empty", 256'(sb.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
